iot_riscv_muldiv: RTL and testbench

- Standalone parametrised multiply/divide unit for the iot_riscv execute stage.
- Replaces the fixed 32-bit divider built into the ALU; adds the full RV32M op set, configurable operand width, an optional single-cycle multiplier, early-out on divide corner cases, and pipeline flush.
- Attaches to the ALU/EX stage through a request/response valid-ready handshake; EX stalls while a request or result is pending.

---
 rtl/iot_riscv_muldiv.sv | 135 +++++++++++++
 tb/tb_iot_riscv_muldiv.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/iot_riscv_muldiv.sv
// RV32M multiply/divide unit: iterative shift-add multiply (or single-cycle when
// fast_mul_p=1) and restoring divide, with divide early-outs and flush.
module iot_riscv_muldiv #(
   parameter int width_p    = 32,
   parameter bit fast_mul_p = 1'b0
) (
   input  logic               main_clk_i,
   input  logic               main_rst_i,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [2:0]         req_op_i,
   input  logic [width_p-1:0] req_a_i,
   input  logic [width_p-1:0] req_b_i,
   input  logic               abort_i,
   output logic               res_valid_o,
   input  logic               res_ready_i,
   output logic [width_p-1:0] res_o,
   output logic               busy_o
);
   localparam int cw_lp = $clog2(width_p);
   localparam int dw_lp = 2 * width_p;

   // state | meaning
   // IDLE  | waiting for a request
   // CALC  | one multiply/divide iteration per cycle
   // FIX   | last iteration, sign correction, result select
   // DONE  | result presented until consumed
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

   state_e             state_q;
   logic [cw_lp-1:0]   cnt_q;
   logic [2:0]         op_q;
   logic [width_p-1:0] a_mag_q, b_mag_q, res_q;
   logic [dw_lp-1:0]   acc_q;
   logic               neg_q_q, neg_r_q;

   logic               accept, is_div, sgn_a, sgn_b, div_zero, div_ovf;
   logic [width_p-1:0] a_mag_d, b_mag_d, special_res;
   logic [dw_lp-1:0]   acc_d, step, final_v, prod_s, fast_prod;
   logic [width_p:0]   mul_sum, shifted;
   logic [width_p-1:0] rem_diff, rem_new, quo_fix, rem_fix, fix_res;
   logic               div_ge;

   assign req_ready_o = (state_q == IDLE) && !abort_i;
   assign accept      = req_valid_i && req_ready_o;
   assign res_valid_o = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);
   assign res_o       = res_q;

   always_comb begin
      is_div   = req_op_i[2];
      sgn_a    = req_a_i[width_p-1] &&
                 (req_op_i == 3'd1 || req_op_i == 3'd2 || req_op_i == 3'd4 || req_op_i == 3'd6);
      sgn_b    = req_b_i[width_p-1] &&
                 (req_op_i == 3'd1 || req_op_i == 3'd4 || req_op_i == 3'd6);
      a_mag_d  = sgn_a ? -req_a_i : req_a_i;
      b_mag_d  = sgn_b ? -req_b_i : req_b_i;
      div_zero = is_div && (req_b_i == '0);
      div_ovf  = (req_op_i == 3'd4 || req_op_i == 3'd6) &&
                 (req_a_i == {1'b1, {(width_p-1){1'b0}}}) && (req_b_i == '1);
      // op[1] selects remainder for the divide ops
      if (div_zero) special_res = req_op_i[1] ? req_a_i : '1;
      else          special_res = req_op_i[1] ? '0 : req_a_i;
      acc_d    = {{width_p{1'b0}}, (is_div ? a_mag_d : b_mag_d)};
   end

   always_comb begin
      mul_sum   = {1'b0, acc_q[dw_lp-1:width_p]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
      shifted   = acc_q[dw_lp-1:width_p-1];
      div_ge    = shifted >= {1'b0, b_mag_q};
      rem_diff  = shifted[width_p-1:0] - b_mag_q;
      rem_new   = div_ge ? rem_diff : shifted[width_p-1:0];
      if (op_q[2]) step = {rem_new, acc_q[width_p-2:0], div_ge};
      else         step = {mul_sum, acc_q[width_p-1:1]};
      fast_prod = dw_lp'(a_mag_q) * dw_lp'(b_mag_q);
      final_v   = (fast_mul_p && !op_q[2]) ? fast_prod : step;
      prod_s    = neg_q_q ? -final_v : final_v;
      quo_fix   = neg_q_q ? -final_v[width_p-1:0] : final_v[width_p-1:0];
      rem_fix   = neg_r_q ? -final_v[dw_lp-1:width_p] : final_v[dw_lp-1:width_p];
      case (op_q)
         3'd0:          fix_res = prod_s[width_p-1:0];
         3'd4, 3'd5:    fix_res = quo_fix;
         3'd6, 3'd7:    fix_res = rem_fix;
         default:       fix_res = prod_s[dw_lp-1:width_p];
      endcase
   end

   always_ff @(posedge main_clk_i) begin
      if (main_rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_mag_q <= '0;
         b_mag_q <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
      end else if (abort_i) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               op_q    <= req_op_i;
               a_mag_q <= a_mag_d;
               b_mag_q <= b_mag_d;
               acc_q   <= acc_d;
               neg_q_q <= sgn_a ^ sgn_b;
               neg_r_q <= sgn_a;
               if (div_zero || div_ovf) begin
                  res_q   <= special_res;
                  state_q <= DONE;
               end else if (fast_mul_p && !is_div) begin
                  state_q <= FIX;
               end else begin
                  cnt_q   <= cw_lp'(width_p - 1);
                  state_q <= CALC;
               end
            end
            CALC: begin
               acc_q <= step;
               cnt_q <= cnt_q - 1'b1;
               // FIX performs the final iteration, so leave as the counter reaches 0
               if (cnt_q == cw_lp'(1)) state_q <= FIX;
            end
            FIX: begin
               res_q   <= fix_res;
               state_q <= DONE;
            end
            DONE: if (res_ready_i) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_iot_riscv_muldiv.sv
// Scoreboard bench: iterative (index 0) and fast-multiply (index 1) units driven
// in parallel with hand-computed expected results and latencies.
`timescale 1ns/1ps
module tb_iot_riscv_muldiv;
   localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
   localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

   typedef struct {
      logic [31:0] res;
      int          lat;
      time         t_acc;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, req_valid, abort, res_ready;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic [1:0]  rdy, vld, bsy;
   logic [31:0] res_w [2];

   exp_t q0[$], q1[$];
   bit   seen [2];
   int   errors = 0, checks = 0;

   always #5 clk = ~clk;

   iot_riscv_muldiv #(.width_p(32), .fast_mul_p(1'b0)) dut (
      .main_clk_i(clk), .main_rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rdy[0]),
      .req_op_i(op), .req_a_i(a), .req_b_i(b), .abort_i(abort), .res_valid_o(vld[0]),
      .res_ready_i(res_ready), .res_o(res_w[0]), .busy_o(bsy[0]));

   iot_riscv_muldiv #(.width_p(32), .fast_mul_p(1'b1)) dut_f (
      .main_clk_i(clk), .main_rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rdy[1]),
      .req_op_i(op), .req_a_i(a), .req_b_i(b), .abort_i(abort), .res_valid_o(vld[1]),
      .res_ready_i(res_ready), .res_o(res_w[1]), .busy_o(bsy[1]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: first valid cycle of each result is compared against the queue head.
   initial forever begin
      exp_t e;
      int   lat;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         if (vld[k] && !seen[k]) begin
            seen[k] = 1'b1;
            if ((k == 0 ? q0.size() : q1.size()) == 0) begin
               chk($sformatf("unexpected_result[%0d]", k), 32'd1, 32'd0);
            end else begin
               e   = (k == 0) ? q0[0] : q1[0];
               lat = int'(($time - 1 - e.t_acc) / 10) + 1;
               chk($sformatf("%s res[%0d]", e.name, k), res_w[k], e.res);
               chk($sformatf("%s latency[%0d]", e.name, k), lat, e.lat);
            end
         end else if (!vld[k] && seen[k]) begin
            seen[k] = 1'b0;
            if (k == 0 && q0.size() > 0) void'(q0.pop_front());
            if (k == 1 && q1.size() > 0) void'(q1.pop_front());
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] exp, input int lat_s, input int lat_f,
                        input bit push, input string nm);
      exp_t e;
      @(negedge clk);
      chk({nm, " req_ready"}, {30'd0, rdy}, 32'd3);
      req_valid = 1'b1; op = o; a = ia; b = ib;
      @(posedge clk);
      if (push) begin
         e.res = exp; e.t_acc = $time; e.name = nm;
         e.lat = lat_s; q0.push_back(e);
         e.lat = lat_f; q1.push_back(e);
      end
      @(negedge clk);
      req_valid = 1'b0; op = 3'd0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while ((bsy != 2'b00 || vld != 2'b00) && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 200) chk({nm, " timeout"}, 32'd1, 32'd0);
   endtask

   task automatic run(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                      input logic [31:0] exp, input int lat_s, input int lat_f, input string nm);
      issue(o, ia, ib, exp, lat_s, lat_f, 1'b1, nm);
      wait_idle(nm);
   endtask

   initial begin
      int  n;
      bit  any_vld;
      rst = 1'b1; req_valid = 1'b0; abort = 1'b0; res_ready = 1'b1;
      op = 3'd0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", {30'd0, bsy}, 32'd0);
      chk("reset valid", {30'd0, vld}, 32'd0);
      chk("reset res0", res_w[0], 32'd0);
      chk("reset res1", res_w[1], 32'd0);
      @(negedge clk); rst = 1'b0;
      #1 chk("ready after reset", {30'd0, rdy}, 32'd3);

      run(OP_DIVU,   32'd100,        32'd7,          32'd14,         33, 33, "divu_100_7");
      run(OP_REMU,   32'd100,        32'd7,          32'd2,          33, 33, "remu_100_7");
      run(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  1,  "div_ovf");
      run(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1,  1,  "rem_ovf");
      run(OP_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF,  1,  1,  "divu_by0");
      run(OP_REMU,   32'd5,          32'd0,          32'd5,          1,  1,  "remu_by0");
      run(OP_REM,    32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1,  1,  "rem_neg_by0");
      run(OP_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, 33, "div_m7_2");
      run(OP_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, 33, "rem_m7_2");
      run(OP_DIV,    32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33, 33, "div_7_m2");
      run(OP_REM,    32'd7,          32'hFFFF_FFFE,  32'd1,          33, 33, "rem_7_m2");
      run(OP_DIV,    32'h8000_0000,  32'd1,          32'h8000_0000,  33, 33, "div_min_1");
      run(OP_MULH,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, 2,  "mulh_m7_2");
      run(OP_MUL,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFF2,  33, 2,  "mul_m7_2");
      run(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33, 2,  "mulhu_max");
      run(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  33, 2,  "mulhsu_max");
      run(OP_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  33, 2,  "mulh_min_min");
      run(OP_MULHSU, 32'h8000_0000,  32'd2,          32'hFFFF_FFFF,  33, 2,  "mulhsu_min_2");
      run(OP_MUL,    32'h1234_5678,  32'd16,         32'h2345_6780,  33, 2,  "mul_x16");
      run(OP_MULHU,  32'h8000_0000,  32'd4,          32'd2,          33, 2,  "mulhu_hi");

      // Result held in DONE while the consumer stalls
      res_ready = 1'b0;
      issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 33, 1'b1, "hold_divu");
      n = 0;
      while (vld != 2'b11 && n < 100) begin @(posedge clk); #1; n++; end
      if (n >= 100) chk("hold wait timeout", 32'd1, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk($sformatf("hold valid c%0d", i), {30'd0, vld}, 32'd3);
         chk($sformatf("hold res c%0d", i), res_w[0] ^ res_w[1] ^ 32'd14, 32'd14);
         chk($sformatf("hold ready c%0d", i), {30'd0, rdy}, 32'd0);
      end
      @(negedge clk); res_ready = 1'b1;
      @(posedge clk); #1;
      chk("release idle", {30'd0, bsy}, 32'd0);
      chk("release valid low", {30'd0, vld}, 32'd0);
      run(OP_REMU, 32'd100, 32'd7, 32'd2, 33, 33, "after_release");

      // Flush in the middle of CALC
      issue(OP_DIVU, 32'd1000, 32'd3, 32'd0, 0, 0, 1'b0, "abort_calc");
      repeat (10) @(posedge clk);
      @(negedge clk); abort = 1'b1;
      @(posedge clk); #1;
      chk("abort busy", {30'd0, bsy}, 32'd0);
      chk("abort valid", {30'd0, vld}, 32'd0);
      @(negedge clk); abort = 1'b0;
      any_vld = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (vld != 2'b00) any_vld = 1'b1; end
      chk("abort no result", {31'd0, any_vld}, 32'd0);

      // Flush blocks acceptance in IDLE
      @(negedge clk); abort = 1'b1; req_valid = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd5;
      #1 chk("abort ready low", {30'd0, rdy}, 32'd0);
      @(posedge clk); #1;
      chk("abort no accept", {30'd0, bsy}, 32'd0);
      @(negedge clk); abort = 1'b0; req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("abort idle no result", {30'd0, vld}, 32'd0);

      // Reset in the middle of CALC
      issue(OP_DIVU, 32'd1000, 32'd3, 32'd0, 0, 0, 1'b0, "reset_calc");
      repeat (5) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("midreset busy", {30'd0, bsy}, 32'd0);
      chk("midreset valid", {30'd0, vld}, 32'd0);
      chk("midreset res0", res_w[0], 32'd0);
      chk("midreset res1", res_w[1], 32'd0);
      @(negedge clk); rst = 1'b0;
      #1 chk("midreset ready", {30'd0, rdy}, 32'd3);
      run(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 33, "after_reset");

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard drained", q0.size() + q1.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
